// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the arbitrated 1024-word RAM:
//   RAM_ADDR_W / RAM_DEPTH : word address width and depth of the shared RAM
//   WSIZE_*                : write-size encoding understood by the RAM
//   slot_e                 : per-requester response slot state
//   wsize_to_be()          : write size -> byte-lane enables (lane 0 = bits 7:0)
// ---------------------------------------------------------------------------
package bram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    // Sub-word writes always land in the low lanes of the addressed word.
    localparam logic [2:0] WSIZE_BYTE = 3'd0;
    localparam logic [2:0] WSIZE_HALF = 3'd1;
    localparam logic [2:0] WSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_FULL     = 2'd2
    } slot_e;

    // Unlisted size codes write the whole word.
    function automatic logic [3:0] wsize_to_be(input logic [2:0] wsize);
        logic [3:0] be;
        case (wsize)
            WSIZE_BYTE: be = 4'b0001;
            WSIZE_HALF: be = 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/bram_align2_1024.sv
// ---------------------------------------------------------------------------
// bram_align2_1024
// 1024 x 32 simple dual-port RAM with registered read and byte-lane writes.
// Ports:
//   clock         : clock, all activity on the rising edge
//   raddr / rdata : read address; rdata is registered (valid one edge later)
//   waddr / wdata : write address and data
//   wsize         : write size (bram_pkg WSIZE_* encoding)
//   wren          : write enable
// Reading and writing the same address on one edge returns the old word.
// The RAM has no reset so its contents survive a system reset.
// ---------------------------------------------------------------------------
module bram_align2_1024
    import bram_pkg::*;
(
    input  logic                  clock,
    input  logic [RAM_ADDR_W-1:0] raddr,
    output logic [31:0]           rdata,
    input  logic [RAM_ADDR_W-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [2:0]            wsize,
    input  logic                  wren
);

    logic [3:0] be;

    assign be = wsize_to_be(wsize);

    // One byte-wide array per lane so each lane maps onto a plain block RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [RAM_DEPTH];
        logic [7:0] rd_reg;

        always_ff @(posedge clock) begin
            if (wren && be[gi]) begin
                mem[waddr] <= wdata[8*gi +: 8];
            end
            rd_reg <= mem[raddr];
        end

        assign rdata[8*gi +: 8] = rd_reg;
    end

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// Two requesters share one bram_align2_1024 through a round-robin arbiter.
// At most one request is accepted per cycle; each requester owns a single
// response slot (EMPTY -> INFLIGHT -> FULL -> EMPTY).
// Ports:
//   clock, reset           : clock; asynchronous active-high reset
//   req_valid / req_ready  : request handshake per requester
//   req_addr, req_wdata,
//   req_wsize, req_wren    : request payload (word address, data, size, 1=write)
//   rsp_valid / rsp_ready  : response handshake per requester
//   rsp_data               : read data (0 for writes), stable while rsp_valid
// Read timing: accepted in cycle N, RAM read registered at the end of N,
// captured into the slot at the end of N+1, rsp_valid from cycle N+2.
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int NREQ       = 2,
    parameter int RAM_ADDR_W = bram_pkg::RAM_ADDR_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][RAM_ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0][31:0]          req_wdata,
    input  logic [NREQ-1:0][2:0]           req_wsize,
    input  logic [NREQ-1:0]                req_wren,
    output logic [NREQ-1:0]                rsp_valid,
    input  logic [NREQ-1:0]                rsp_ready,
    output logic [NREQ-1:0][31:0]          rsp_data
);

    import bram_pkg::*;

    logic            rr_reg;
    logic            rr_next;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            win;
    logic            accept;
    logic            ram_wren;
    logic [31:0]     ram_rdata;

    // Arbitration. With both eligible the pointer decides; a lone eligible
    // requester wins regardless. With none eligible, grant[win] is simply 0.
    // Reset blocks every grant so the RAM cannot be written during reset.
    always_comb begin
        grant = '0;
        win   = rr_reg;
        if (!reset) begin
            if (eligible[0] && eligible[1]) begin
                win = rr_reg;
            end else if (eligible[0]) begin
                win = 1'b0;
            end else if (eligible[1]) begin
                win = 1'b1;
            end
            grant[win] = eligible[win];
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign rr_next   = accept ? ~win : rr_reg;
    assign ram_wren  = accept && req_wren[win];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_reg <= 1'b0;
        end else begin
            rr_reg <= rr_next;
        end
    end

    // The RAM is always addressed by the current winner; only the write
    // enable depends on whether anything was actually accepted.
    bram_align2_1024 u_ram (
        .clock (clock),
        .raddr (req_addr[win]),
        .rdata (ram_rdata),
        .waddr (req_addr[win]),
        .wdata (req_wdata[win]),
        .wsize (req_wsize[win]),
        .wren  (ram_wren)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        slot_e       slot_reg;
        slot_e       slot_next;
        logic        wr_reg;
        logic [31:0] data_reg;

        // A slot only takes a new request once it is EMPTY at the start of
        // the cycle, so the FULL->EMPTY cycle can never also accept.
        assign eligible[gi] = req_valid[gi] && (slot_reg == SLOT_EMPTY);

        always_comb begin
            slot_next = slot_reg;
            unique case (slot_reg)
                SLOT_EMPTY:    if (grant[gi])     slot_next = SLOT_INFLIGHT;
                SLOT_INFLIGHT:                    slot_next = SLOT_FULL;
                SLOT_FULL:     if (rsp_ready[gi]) slot_next = SLOT_EMPTY;
                default:                          slot_next = SLOT_EMPTY;
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                slot_reg <= SLOT_EMPTY;
                wr_reg   <= 1'b0;
                data_reg <= '0;
            end else begin
                slot_reg <= slot_next;
                if (grant[gi]) begin
                    wr_reg <= req_wren[gi];
                end
                // RAM output holds this slot's read during its INFLIGHT cycle,
                // even if the other requester is accepted in that same cycle.
                if (slot_reg == SLOT_INFLIGHT) begin
                    data_reg <= wr_reg ? 32'd0 : ram_rdata;
                end
            end
        end

        assign rsp_valid[gi] = (slot_reg == SLOT_FULL);
        assign rsp_data[gi]  = data_reg;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// Directed bench for bram_arbiter. A reference model (word-array memory,
// per-requester "edges since acceptance" counter, round-robin pointer) is
// checked against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_arbiter;
    import bram_pkg::*;

    localparam int AW = 10;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][31:0]    req_wdata;
    logic [1:0][2:0]     req_wsize;
    logic [1:0]          req_wren;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [1:0][31:0]    rsp_data;
    logic [1:0]          rsp_hold = 2'b00;

    assign rsp_ready = ~rsp_hold;

    always #5 clock = ~clock;

    bram_arbiter #(.NREQ(2), .RAM_ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wsize (req_wsize),
        .req_wren  (req_wren),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] data;
        logic [2:0]  wsize;
    } cmd_t;

    cmd_t        cq0[$];
    cmd_t        cq1[$];
    logic [31:0] got0[$];
    logic [31:0] got1[$];
    int          grant_log[$];
    logic [1:0]  drv_hs = 2'b00;
    int          acc_cyc[2];
    int          rise_cyc[2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    function automatic cmd_t wr_cmd(input logic [10:0] a, input logic [31:0] d, input logic [2:0] s);
        cmd_t c;
        c.wr = 1'b1; c.addr = a; c.data = d; c.wsize = s;
        return c;
    endfunction

    function automatic cmd_t rd_cmd(input logic [10:0] a);
        cmd_t c;
        c.wr = 1'b0; c.addr = a; c.data = 32'd0; c.wsize = WSIZE_WORD;
        return c;
    endfunction

    // ---------------- request driver (changes inputs at posedge+1) --------
    task automatic present(input int i, input cmd_t c);
        req_valid[i] = 1'b1;
        req_wren[i]  = c.wr;
        req_addr[i]  = c.addr[AW-1:0];   // 11-bit command addresses wrap here
        req_wdata[i] = c.data;
        req_wsize[i] = c.wsize;
        $display("REQ  r%0d %s addr=%h data=%h size=%0d", i, c.wr ? "WR" : "RD", c.addr, c.data, c.wsize);
    endtask

    initial begin : driver
        req_valid = '0; req_addr = '0; req_wdata = '0; req_wsize = '0; req_wren = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (drv_hs[i]) req_valid[i] = 1'b0;
            end
            if (!req_valid[0] && cq0.size() > 0) present(0, cq0.pop_front());
            if (!req_valid[1] && cq1.size() > 0) present(1, cq1.pop_front());
        end
    end

    // ---------------- reference model + per-cycle compare -----------------
    initial begin : model
        logic [31:0] mmem [1024];
        logic [1:0]  m_busy;
        int          m_age [2];
        logic [31:0] m_data [2];
        int          m_rr;
        int          cyc;
        logic [1:0]  prev_v;
        int          w;
        int          a;
        logic [1:0]  exp_ready;
        logic        exp_v;
        logic [31:0] old;

        m_busy = '0; m_rr = 0; cyc = 0; prev_v = '0;
        for (int i = 0; i < 1024; i++) mmem[i] = 32'd0;
        forever begin
            @(negedge clock);
            cyc++;
            drv_hs = req_valid & req_ready;
            for (int i = 0; i < 2; i++) begin
                if (drv_hs[i]) begin
                    acc_cyc[i] = cyc;
                    grant_log.push_back(i);
                end
                if (rsp_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
                prev_v[i] = rsp_valid[i];
            end
            if (reset) begin
                chk("reset_req_ready", 0, 32'(req_ready), 32'd0);
                chk("reset_rsp_valid", 0, 32'(rsp_valid), 32'd0);
                chk("reset_rsp_data", 0, rsp_data[0], 32'd0);
                chk("reset_rsp_data", 1, rsp_data[1], 32'd0);
                m_busy = '0;
                m_rr   = 0;
            end else begin
                // Who may be served this cycle, and who is served.
                w = -1;
                if (req_valid[0] && !m_busy[0] && req_valid[1] && !m_busy[1]) w = m_rr;
                else if (req_valid[0] && !m_busy[0]) w = 0;
                else if (req_valid[1] && !m_busy[1]) w = 1;
                exp_ready = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
                chk("req_ready", 0, 32'(req_ready), 32'(exp_ready));
                chk("both_ready", 0, 32'(req_ready == 2'b11), 32'd0);
                for (int i = 0; i < 2; i++) begin
                    exp_v = m_busy[i] && (m_age[i] >= 2);
                    chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(exp_v));
                    if (exp_v) chk("rsp_data", i, rsp_data[i], m_data[i]);
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        $display("RSP  r%0d data=%h", i, rsp_data[i]);
                        if (i == 0) got0.push_back(rsp_data[i]);
                        else        got1.push_back(rsp_data[i]);
                    end
                end
                // Advance to the next cycle.
                for (int i = 0; i < 2; i++) begin
                    if (m_busy[i]) begin
                        if (m_age[i] >= 2) begin
                            if (rsp_ready[i]) m_busy[i] = 1'b0;
                        end else begin
                            m_age[i]++;
                        end
                    end
                end
                if (w >= 0) begin
                    m_busy[w] = 1'b1;
                    m_age[w]  = 1;
                    m_rr      = 1 - w;
                    a         = int'(req_addr[w]) % 1024;
                    if (req_wren[w]) begin
                        old = mmem[a];
                        case (req_wsize[w])
                            WSIZE_BYTE: mmem[a] = {old[31:8], req_wdata[w][7:0]};
                            WSIZE_HALF: mmem[a] = {old[31:16], req_wdata[w][15:0]};
                            default:    mmem[a] = req_wdata[w];
                        endcase
                        m_data[w] = 32'd0;
                    end else begin
                        m_data[w] = mmem[a];
                    end
                end
            end
        end
    end

    // ---------------- helpers for the directed sequences ------------------
    // Inputs and queues are touched at posedge+2, after the driver has run.
    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((cq0.size() != 0 || cq1.size() != 0 || req_valid != 2'b00 || rsp_valid != 2'b00) && t < 400) begin
            @(negedge clock);
            t++;
        end
        repeat (4) @(negedge clock);
        #1;
        chk("drain_idle", 0, 32'(req_valid | rsp_valid), 32'd0);
    endtask

    task automatic clear_logs();
        got0.delete();
        got1.delete();
        grant_log.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequences ----------------------------------
    initial begin : main
        int t;
        int cnt;

        // Single write + read queued while reset is held: nothing may be
        // accepted until release.
        reset = 1'b1;
        cq0.push_back(wr_cmd(11'h011, 32'h12345678, WSIZE_WORD));
        cq0.push_back(rd_cmd(11'h011));
        repeat (3) @(negedge clock);
        sync();
        reset = 1'b0;
        drain();
        chk("single_count", 0, 32'(got0.size()), 32'd2);
        if (got0.size() >= 2) begin
            chk("single_wr_rsp", 0, got0[0], 32'd0);
            chk("single_rd_data", 0, got0[1], 32'h12345678);
        end
        chk("single_latency", 0, 32'(rise_cyc[0] - acc_cyc[0]), 32'd2);

        // Reset one cycle after a read from requester 0 is accepted.
        clear_logs();
        sync();
        cq0.push_back(rd_cmd(11'h011));
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!(req_valid[0] && req_ready[0]) && t < 20);
        chk("mid_reset_accept", 0, 32'(req_valid[0] && req_ready[0]), 32'd1);
        sync();
        reset = 1'b1;
        repeat (2) sync();
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        chk("mid_reset_no_rsp", 0, 32'(got0.size()), 32'd0);

        // Contention straight after reset: pointer is back at requester 0.
        clear_logs();
        sync();
        for (int k = 0; k < 4; k++) begin
            cq0.push_back(rd_cmd(11'h011));
            cq1.push_back(rd_cmd(11'h011));
        end
        drain();
        chk("cont_grants", 0, 32'(grant_log.size()), 32'd8);
        if (grant_log.size() >= 4) begin
            chk("cont_grant", 0, 32'(grant_log[0]), 32'd0);
            chk("cont_grant", 1, 32'(grant_log[1]), 32'd1);
            chk("cont_grant", 2, 32'(grant_log[2]), 32'd0);
            chk("cont_grant", 3, 32'(grant_log[3]), 32'd1);
        end
        if (got1.size() >= 4) chk("cont_reread", 1, got1[3], 32'h12345678);

        // Backpressure on requester 1 while requester 0 streams.
        clear_logs();
        sync();
        rsp_hold[1] = 1'b1;
        cq1.push_back(rd_cmd(11'h011));
        cq1.push_back(rd_cmd(11'h011));
        for (int k = 0; k < 8; k++) cq0.push_back(rd_cmd(11'h011));
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!rsp_valid[1] && t < 20);
        chk("bp_full_seen", 1, 32'(rsp_valid[1]), 32'd1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("bp_valid", 1, 32'(rsp_valid[1]), 32'd1);
            chk("bp_data", 1, rsp_data[1], 32'h12345678);
            chk("bp_ready", 1, 32'(req_ready[1]), 32'd0);
            if (k < 9 && req_valid[0] && req_ready[0]) cnt++;
        end
        chk("bp_r0_rate", 0, 32'(cnt), 32'd3);
        sync();
        rsp_hold[1] = 1'b0;
        drain();
        chk("bp_count", 0, 32'(got0.size()), 32'd8);
        chk("bp_count", 1, 32'(got1.size()), 32'd2);

        // Write then read on the very next cycle, address aliasing, sub-word writes.
        clear_logs();
        sync();
        cq0.push_back(wr_cmd(11'h3FF, 32'hA5A5A5A5, WSIZE_WORD));
        sync();
        cq1.push_back(rd_cmd(11'h3FF));
        drain();
        if (got1.size() >= 1) chk("wtr_data", 1, got1[0], 32'hA5A5A5A5);
        else chk("wtr_count", 1, 32'(got1.size()), 32'd1);
        sync();
        cq0.push_back(wr_cmd(11'h000, 32'h0BADF00D, WSIZE_WORD));
        drain();
        sync();
        cq1.push_back(rd_cmd(11'h400));
        drain();
        chk("alias_count", 1, 32'(got1.size()), 32'd2);
        if (got1.size() >= 2) chk("alias_data", 1, got1[1], 32'h0BADF00D);
        clear_logs();
        sync();
        cq0.push_back(wr_cmd(11'h020, 32'hFFFFFFFF, WSIZE_WORD));
        cq0.push_back(wr_cmd(11'h020, 32'h000000AB, WSIZE_BYTE));
        cq0.push_back(rd_cmd(11'h020));
        cq1.push_back(wr_cmd(11'h021, 32'hFFFFFFFF, WSIZE_WORD));
        cq1.push_back(wr_cmd(11'h021, 32'h00001234, WSIZE_HALF));
        cq1.push_back(rd_cmd(11'h021));
        drain();
        if (got0.size() >= 3) chk("byte_write", 0, got0[2], 32'hFFFFFFAB);
        else chk("byte_count", 0, 32'(got0.size()), 32'd3);
        if (got1.size() >= 3) chk("half_write", 1, got1[2], 32'hFFFF1234);
        else chk("half_count", 1, 32'(got1.size()), 32'd3);

        // Sweep: 16 words at i*17, read back interleaved from both requesters.
        clear_logs();
        sync();
        for (int i = 0; i < 16; i++) cq0.push_back(wr_cmd(11'(i * 17), 32'(i), WSIZE_WORD));
        drain();
        clear_logs();
        sync();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) cq0.push_back(rd_cmd(11'(i * 17)));
            else            cq1.push_back(rd_cmd(11'(i * 17)));
        end
        drain();
        chk("sweep_count", 0, 32'(got0.size()), 32'd8);
        chk("sweep_count", 1, 32'(got1.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got0.size()) chk("sweep_even", k, got0[k], 32'(2 * k));
            if (k < got1.size()) chk("sweep_odd", k, got1[k], 32'(2 * k + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters; only 2 is supported.
REQ-002 SHALL have parameter RAM_ADDR_W, default 10, meaning word address width of the shared 1024-word RAM.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, [NREQ], per-requester request valid.
REQ-006 SHALL have port req_ready, output, [NREQ], per-requester request accepted this cycle.
REQ-007 SHALL have port req_addr, input, [NREQ][RAM_ADDR_W], per-requester word address.
REQ-008 SHALL have port req_wdata, input, [NREQ][32], per-requester write data.
REQ-009 SHALL have port req_wsize, input, [NREQ][3], per-requester write size, encoded as in the shared RAM.
REQ-010 SHALL have port req_wren, input, [NREQ], 1 = write, 0 = read.
REQ-011 SHALL have port rsp_valid, output, [NREQ], per-requester response valid.
REQ-012 SHALL have port rsp_ready, input, [NREQ], per-requester response consumed.
REQ-013 SHALL have port rsp_data, output, [NREQ][32], per-requester read data.

Function
REQ-014 SHALL accept at most one request per cycle in total; a handshake is req_valid[i] && req_ready[i].
REQ-015 SHALL keep one response slot per requester, with states EMPTY, INFLIGHT and FULL.
REQ-016 SHALL mark requester i eligible only when req_valid[i]=1 and slot[i]=EMPTY.
REQ-017 SHALL drive req_ready[i] combinationally: requester i is eligible and wins arbitration.
REQ-018 SHALL arbitrate round-robin: pointer rr selects the winner when both are eligible; a lone eligible requester wins regardless of rr.
REQ-019 SHALL set rr to the other requester after every accepted request; rr is unchanged when nothing is accepted.
REQ-020 SHALL, in the acceptance cycle, drive the RAM combinationally from the winner (raddr=waddr=req_addr, wdata, wsize, wren); with no winner, the RAM wren SHALL be 0.
REQ-021 SHALL move slot[i] EMPTY->INFLIGHT on acceptance, INFLIGHT->FULL on the next edge, and FULL->EMPTY on the edge where rsp_ready[i]=1.
REQ-022 SHALL, on INFLIGHT->FULL, capture RAM out into rsp_data[i] for reads and 0 for writes.
REQ-023 SHALL hold rsp_valid[i]=1 exactly while slot[i]=FULL, and hold rsp_data[i] stable during that time.
REQ-024 SHALL give a read latency of 2 edges: request accepted at edge N, rsp_valid high after edge N+2.
REQ-025 SHALL not accept a new request from requester i in the same cycle as FULL->EMPTY; the earliest re-acceptance is the following cycle, giving a throughput of one request per 3 cycles per requester.
REQ-026 SHALL return data written by an earlier accepted write to any later read of the same address, including a read accepted on the very next cycle.
REQ-027 SHALL keep the other requester's slot progressing independently while one requester's slot is stalled FULL.
REQ-028 SHALL wrap addresses only through RAM_ADDR_W truncation, with no range checking.

Reset
REQ-029 SHALL, while reset=1, force all slots to EMPTY, rr=0, rsp_valid=0, rsp_data=0, req_ready=0 and the RAM wren to 0.
REQ-030 SHALL discard any in-flight request when reset is asserted mid-operation, producing no response after reset release.
REQ-031 SHALL not alter RAM contents on reset.

Structure
REQ-032 SHALL take RAM_ADDR_W, the wsize encoding and the slot-state enum from a shared package bram_pkg.
REQ-033 SHALL instantiate exactly one bram_align2_1024 as its sub-module.
REQ-034 SHALL keep all arbitration and slot logic in bram_arbiter, with no further sub-modules.

Verification
REQ-035 SHALL cover a single read: requester 0 writes 0x12345678 to address 0x011, then reads 0x011; expect rsp_data[0]=0x12345678, with rsp_valid[0] rising 2 edges after read acceptance.
REQ-036 SHALL cover contention: both requesters hold valid every cycle after reset; expect grants alternating 0,1,0,1 and never both req_ready high in one cycle.
REQ-037 SHALL cover backpressure: hold rsp_ready[1]=0 for 10 cycles with a response FULL; expect rsp_valid[1] and rsp_data[1] stable, req_ready[1]=0, and requester 0 continuing at one request per 3 cycles.
REQ-038 SHALL cover write-then-read: write 0xA5A5A5A5 to 0x3FF, then read 0x3FF on the next cycle; expect 0xA5A5A5A5. A read of address 0x400 SHALL alias to 0x000.
REQ-039 SHALL cover reset mid-operation: assert reset one cycle after a read is accepted; expect no rsp_valid after release, rr=0, and earlier-written data intact on re-read.
REQ-040 SHALL cover a sweep: write 16 words at addr=i*17 with data=i, then read them all back from both requesters interleaved; all values must match.
